nibble_serial_adder: RTL and testbench

// - Upstream sequencer for the 4-bit ripple_adder stage. Adds two WIDTH-bit operands
//   one nibble per clock through a single ripple_adder instance.
// - The carry is held in a register between cycles.
// - Accepts operands on a valid/ready input handshake. Returns sum, carry-out and

---
 rtl/nibble_serial_adder_pkg.sv | 18 +
 rtl/nibble_serial_adder_if.sv | 29 ++
 rtl/ripple_adder.sv | 15 +
 rtl/nibble_serial_adder.sv | 120 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, nibble width
// and the elaboration-time operand width rule.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operand width must split into whole nibbles and span at least two of them.
    function automatic bit width_ok(input int w);
        return ((w % NIBBLE_W) == 0) && (w >= 2 * NIBBLE_W);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between the operand source, the adder and
// the result consumer.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    // Operand source / result consumer side.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/ripple_adder.sv
// 4-bit adder stage shared by every nibble cycle of the serial adder.
module ripple_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    // Purely combinational nibble add; the carry out feeds the carry register.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per clock through a single 4-bit
// adder, carrying between nibbles in a register. Valid/ready on both sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = $clog2(NIB);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_sh_q, a_sh_d;
    logic [WIDTH-1:0]    b_sh_q, b_sh_d;
    logic [WIDTH-1:0]    sum_sh_q, sum_sh_d;
    logic                carry_q, carry_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cout_q, cout_d;
    logic                ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] ns;
    logic                nc;
    logic                last_nib;

    ripple_adder u_nibble_add (
        .a    (a_sh_q[NIBBLE_W-1:0]),
        .b    (b_sh_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .sum  (ns),
        .cout (nc)
    );

    assign last_nib = (cnt_q == CNT_W'(NIB - 1));

    // Next-state, operand shifting and result capture for IDLE -> RUN -> DONE.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sh_d = {ns, sum_sh_q[WIDTH-1:NIBBLE_W]};
                carry_d  = nc;
                a_sh_d   = a_sh_q >> NIBBLE_W;
                b_sh_d   = b_sh_q >> NIBBLE_W;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_nib) begin
                    // Signed overflow: like-signed operands whose top nibble sum flips sign.
                    ovf_d   = (a_sh_q[NIBBLE_W-1] == b_sh_q[NIBBLE_W-1]) &&
                              (ns[NIBBLE_W-1] != a_sh_q[NIBBLE_W-1]);
                    cout_d  = nc;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: shift registers are cleared too so sum reads 0 straight out of reset.
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_sh_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: randomized and directed adds against an arithmetic
// reference model, with a per-cycle compare of handshake and result outputs.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;
    localparam int BOUND = 50;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    logic clk;
    logic rst_n;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic, no nibbles.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c);
        logic [WIDTH:0] t;
        res_t r;
        t      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        r.sum  = t[WIDTH-1:0];
        r.cout = t[WIDTH];
        r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    // Scoreboard: pending result, accept time, and "nothing accepted since reset".
    res_t pend[$];
    int   cyc     = 0;
    int   acc_cyc = 0;
    bit   fresh   = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            fresh = 1'b1;
        end else begin
            cyc++;
            if (bus.in_valid && bus.in_ready) begin
                pend.push_back(model(bus.a, bus.b, bus.cin));
                acc_cyc = cyc;
                fresh   = 1'b0;
            end
            if (bus.out_valid && bus.out_ready && pend.size() != 0) begin
                void'(pend.pop_front());
            end
        end
    end

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        bit idle;
        bit exp_ov;
        if (!rst_n) begin
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_in_ready",  32'(bus.in_ready),  32'd1);
            check("rst_busy",      32'(bus.busy),      32'd0);
            check("rst_sum",       32'(bus.sum),       32'd0);
        end else begin
            idle   = (pend.size() == 0);
            exp_ov = !idle && ((cyc - acc_cyc) >= NIB);
            check("in_ready",  32'(bus.in_ready),  32'(idle));
            check("busy",      32'(bus.busy),      32'(!idle));
            check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            if (exp_ov) begin
                check("sum",  32'(bus.sum),  32'(pend[0].sum));
                check("cout", 32'(bus.cout), 32'(pend[0].cout));
                check("ovf",  32'(bus.ovf),  32'(pend[0].ovf));
            end
            if (fresh) begin
                check("idle_sum",  32'(bus.sum),  32'd0);
                check("idle_cout", 32'(bus.cout), 32'd0);
                check("idle_ovf",  32'(bus.ovf),  32'd0);
            end
        end
    end

    // Present operands until accepted, then scramble them.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        n = 0;
        while (!bus.in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = WIDTH'($urandom);
        bus.b        = WIDTH'($urandom);
        bus.cin      = 1'($urandom);
    endtask

    // Wait for out_valid (poking ignored inputs meanwhile), capture, then stall `hold` cycles.
    task automatic wait_result(input int hold, output res_t r);
        int n;
        n = 0;
        while (!bus.out_valid && n < BOUND) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("result_timeout", 32'(bus.out_valid), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        r.sum  = bus.sum;
        r.cout = bus.cout;
        r.ovf  = bus.ovf;
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic c,
                            input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        res_t r;
        res_t m;
        m = model(a, b, c);
        check({name, "_model_sum"}, 32'(m.sum), 32'(es));
        check({name, "_model_cout"}, 32'(m.cout), 32'(ec));
        check({name, "_model_ovf"}, 32'(m.ovf), 32'(eo));
        send(a, b, c);
        wait_result(0, r);
        check({name, "_sum"}, 32'(r.sum), 32'(es));
        check({name, "_cout"}, 32'(r.cout), 32'(ec));
        check({name, "_ovf"}, 32'(r.ovf), 32'(eo));
    endtask

    initial begin
        res_t r;
        res_t held;
        int   n;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        directed("add_1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        directed("carry_all", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        directed("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure: stall DONE 5 cycles while a second request waits.
        send(16'h7FFF, 16'h0001, 1'b0);
        n = 0;
        while (!bus.out_valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("bp_timeout", 32'(bus.out_valid), 32'd1);
        held.sum  = bus.sum;
        held.cout = bus.cout;
        held.ovf  = bus.ovf;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 16'h1111;
        bus.b         = 16'h2222;
        bus.cin       = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_sum_held", 32'(bus.sum), 32'(held.sum));
        end
        check("bp_sum", 32'(held.sum), 32'h8000);
        check("bp_ovf", 32'(held.ovf), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_back_idle", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_second_taken", 32'(bus.busy), 32'd1);
        wait_result(0, r);
        check("bp_second_sum", 32'(r.sum), 32'h3333);

        // Reset two cycles into RUN: operation discarded.
        send(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrun_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (NIB + 2) @(negedge clk);
        check("midrun_no_result", 32'(bus.out_valid), 32'd0);
        directed("after_rst", 16'h000A, 16'h0002, 1'b1, 16'h000D, 1'b0, 1'b0);

        // Randomized adds with random stalls and gaps; compare process checks results.
        for (int i = 0; i < 60; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            case ($urandom_range(0, 3))
                0:       ra = 16'hFFFF;
                1:       ra = 16'h8000;
                default: ra = WIDTH'($urandom);
            endcase
            rb = WIDTH'($urandom);
            send(ra, rb, 1'($urandom));
            wait_result($urandom_range(0, 3), r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
